// File: rtl/pipe_pkg.sv
// Shared constants and stage payload types for the MIPS pipeline registers.
package pipe_pkg;

    // All-zero word decodes as sll $0,$0,0, i.e. a NOP.
    localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;
    localparam logic [31:0] PIPE_RST_VAL   = NOP_INSTR;
    localparam logic [31:0] PIPE_FLUSH_VAL = NOP_INSTR;

    // F/D payload
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus4;
    } ctrl_d_t;

    // D/E payload
    typedef struct packed {
        logic [3:0]  alu_op;
        logic        alu_src;
        logic        reg_dst;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [31:0] imm;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } ctrl_e_t;

    // E/M payload
    typedef struct packed {
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic [31:0] alu_res;
        logic [31:0] store_val;
        logic [4:0]  wr_reg;
    } ctrl_m_t;

    // M/W payload
    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic [31:0] alu_res;
        logic [31:0] load_val;
        logic [4:0]  wr_reg;
    } ctrl_w_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// One-entry skid buffer for pipe_stage_reg. Only built when PIPE_STAGE_SKID_EN is defined.
// Priority: clear > load > pop.
`ifdef PIPE_STAGE_SKID_EN
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             pop_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    // Next-state for the single parked entry.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (pop_i) begin
            valid_d = 1'b0;
        end
    end

    // Entry register, async reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule
`endif

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, hazard stall/flush and a saturating
// bubble counter. Define PIPE_STAGE_SKID_EN to add a one-entry skid buffer that removes the
// combinational out_ready -> in_ready path.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RST_VAL   = WIDTH'(PIPE_RST_VAL),
    parameter logic [WIDTH-1:0] FLUSH_VAL = WIDTH'(PIPE_FLUSH_VAL),
    parameter int unsigned      CNT_W     = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             stall_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic [CNT_W-1:0] bubble_cnt_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] bub_q, bub_d;
    logic             in_fire, out_fire;

    // Stall masks the output so nothing leaves a frozen stage.
    assign out_valid_o = valid_q & ~stall_i;
    assign in_fire     = in_valid_i & in_ready_o;
    assign out_fire    = out_valid_o & out_ready_i;

`ifdef PIPE_STAGE_SKID_EN
    logic             skid_valid;
    logic             skid_load, skid_pop;
    logic [WIDTH-1:0] skid_data;

    pipe_skid_buf #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (skid_load),
        .pop_i   (skid_pop),
        .clear_i (flush_i),
        .data_i  (in_data_i),
        .valid_o (skid_valid),
        .data_o  (skid_data)
    );

    // Flush always drains upstream; otherwise accept while the skid slot is free.
    assign in_ready_o = flush_i | (~stall_i & ~skid_valid);

    // Main-entry next state; skid refills main before any new payload is taken.
    always_comb begin
        valid_d   = valid_q;
        data_d    = data_q;
        skid_load = 1'b0;
        skid_pop  = 1'b0;
        if (flush_i) begin
            valid_d = 1'b0;
            data_d  = FLUSH_VAL;
        end else if (!stall_i) begin
            if (out_fire && skid_valid) begin
                data_d   = skid_data;
                skid_pop = 1'b1;
            end else if (in_fire && valid_q && !out_fire) begin
                skid_load = 1'b1;
            end else if (in_fire) begin
                valid_d = 1'b1;
                data_d  = in_data_i;
            end else if (out_fire) begin
                valid_d = 1'b0;
            end
        end
    end
`else
    // Flush always drains upstream; otherwise accept when empty or emptying this cycle.
    assign in_ready_o = flush_i | (~stall_i & (~valid_q | out_ready_i));

    // Single-entry next state: flush > stall > load > drain.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
            data_d  = FLUSH_VAL;
        end else if (!stall_i) begin
            if (in_fire) begin
                valid_d = 1'b1;
                data_d  = in_data_i;
            end else if (out_fire) begin
                valid_d = 1'b0;
            end
        end
    end
`endif

    // Bubble counter: count cycles with no valid output, stick at all-ones.
    always_comb begin
        bub_d = bub_q;
        if (!out_valid_o && (bub_q != '1)) begin
            bub_d = bub_q + CNT_W'(1);
        end
    end

    // Stage state registers, async reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= RST_VAL;
            bub_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            bub_q   <= bub_d;
        end
    end

    assign out_data_o   = data_q;
    assign bubble_cnt_o = bub_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg. Works with or without PIPE_STAGE_SKID_EN.
module tb_pipe_stage_reg;

    localparam int unsigned W  = 32;
    localparam int unsigned CW = 4;
    localparam logic [W-1:0] RSTV = 32'h1234_5678;
    localparam logic [W-1:0] FLV  = 32'hFFFF_0000;
    localparam int BUB_MAX = (2 ** CW) - 1;
`ifdef PIPE_STAGE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic          clk = 1'b0;
    logic          rst, flush, stall, in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0]  in_data, out_data;
    logic [CW-1:0] bubble_cnt;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .WIDTH     (W),
        .RST_VAL   (RSTV),
        .FLUSH_VAL (FLV),
        .CNT_W     (CW)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .flush_i      (flush),
        .stall_i      (stall),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_data_i    (in_data),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_data_o   (out_data),
        .bubble_cnt_o (bubble_cnt)
    );

    int checks   = 0;
    int failures = 0;

    // Reference: ordered list of accepted payloads still owed downstream.
    logic [W-1:0] sb_q[$];
    logic [W-1:0] hold_data;
    int           bub_model;
    bit           mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        sb_q.delete();
        hold_data = RSTV;
        bub_model = 0;
    endtask

    // Monitor: compare DUT against the reference, then advance the reference.
    always @(negedge clk) begin
        if (mon_en) begin
            bit           exp_valid, exp_ready;
            logic [W-1:0] exp_data;
            exp_valid = (sb_q.size() > 0) && !stall;
            if (CAP == 2) exp_ready = flush || (!stall && sb_q.size() < 2);
            else          exp_ready = flush || (!stall && (sb_q.size() == 0 || out_ready));
            exp_data = (sb_q.size() > 0) ? sb_q[0] : hold_data;
            check("out_valid", 64'(out_valid), 64'(exp_valid));
            check("in_ready", 64'(in_ready), 64'(exp_ready));
            check("out_data", 64'(out_data), 64'(exp_data));
            check("bubble_cnt", 64'(bubble_cnt), 64'(bub_model));
            if (!exp_valid && bub_model < BUB_MAX) bub_model++;
            if (exp_valid && out_ready) hold_data = sb_q.pop_front();
            if (flush) begin
                sb_q.delete();
                hold_data = FLV;
            end else if (in_valid && exp_ready) begin
                sb_q.push_back(in_data);
            end
        end
    end

    task automatic drive(input bit iv, input logic [W-1:0] d, input bit ordy, input bit st,
                         input bit fl);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        stall     = st;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; stall = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_out_data", 64'(out_data), 64'(RSTV));
        check("reset_bubble", 64'(bubble_cnt), 64'(0));
        check("reset_in_ready", 64'(in_ready), 64'(1));
        mon_en = 1'b1;

        // Streaming 1..8 at full rate.
        for (int i = 1; i <= 8; i++) drive(1'b1, W'(i), 1'b1, 1'b0, 1'b0);
        repeat (2) drive(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Stall holding DEADBEEF; in_valid/out_ready must be ignored.
        drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
        repeat (3) drive(1'b1, 32'h1111_1111, 1'b1, 1'b1, 1'b0);
        repeat (2) drive(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Flush and stall together with a full stage.
        drive(1'b1, 32'hA5A5_A5A5, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'hBAD0_BAD0, 1'b1, 1'b1, 1'b1);
        repeat (2) drive(1'b0, '0, 1'b0, 1'b0, 1'b0);

        // Backpressure: 4 cycles of offered data with out_ready low, then drain.
        for (int i = 0; i < 4; i++) drive(1'b1, W'(100 + i), 1'b0, 1'b0, 1'b0);
        repeat (3) drive(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Async reset mid-cycle while holding a valid payload.
        drive(1'b1, 32'h00C0_FFEE, 1'b0, 1'b0, 1'b0);
        mon_en = 1'b0;
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", 64'(out_valid), 64'(0));
        check("async_rst_out_data", 64'(out_data), 64'(RSTV));
        check("async_rst_bubble", 64'(bubble_cnt), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        mon_en = 1'b1;

        // Idle: counter climbs from 0 and sticks at its maximum.
        repeat (20) drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("bubble_saturated", 64'(bubble_cnt), 64'(BUB_MAX));

        // Randomised traffic with occasional stall and flush.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
        end
        repeat (4) drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("drained", 64'(sb_q.size()), 64'(0));

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
